i_scan_controller: RTL and testbench
====================================

# i_scan_controller

Sequencer for image pixel reads: walks a programmed width×height frame one pixel at a time, issuing one read request per pixel with a `rd_req`/`rd_ack` handshake. It sits between the frame-level control FSM and the pixel memory interface. It generates the column/row index (13-bit, same range as the image column counter) and the linear pixel address `base + row*width + col`, computed incrementally with no multiplier.

## Interface
- `ADDR_W`, 32, width of base and read address
- `clk` in 1, system clock, rising edge
- `n_rst` in 1, asynchronous active-low reset
- `start` in 1, begin a frame scan; sampled only in IDLE
- `abort` in 1, synchronous abort of a scan in progress
- `img_width` in 13, pixels per row; must be ≥1
- `img_height` in 13, rows per frame; must be ≥1
- `base_addr` in ADDR_W, address of pixel (0,0)
- `rd_req` out 1, read request, held until acked
- `rd_addr` out ADDR_W, address of the requested pixel; stable while `rd_req`=1
- `rd_ack` in 1, request accepted this cycle; may be combinational from `rd_req`
- `cur_col` out 13, column of the current request
- `cur_row` out 13, row of the current request
- `busy` out 1, scan in progress
- `done` out 1, one-cycle pulse after the last pixel is acked
- `cfg_err` out 1, one-cycle pulse when `start` arrives with a zero dimension

## Operation
- States: IDLE, REQ, DONE.
- IDLE:
  - `busy`=0, `rd_req`=0.
  - On `start`=1 with both dims nonzero: latch width, height and base, set col=0, row=0, addr=base, and go to REQ.
  - On `start`=1 with either dim zero: pulse `cfg_err` and stay in IDLE.
- REQ:
  - `busy`=1 and `rd_req`=1.
  - If `rd_ack`=0, hold all state.
  - If `rd_ack`=1 on the last pixel, go to DONE.
  - If `rd_ack`=1 on any other pixel, advance position, stay in REQ, and keep `rd_req` high. This gives back-to-back requests at up to one per cycle.
- Advance (raster):
  - Within a row: col+1, addr+1.
  - At col==width−1: col=0, row+1, addr=row_base+width, and row_base updates to that value.
- Last pixel: col==width−1 and row==height−1 (serpentine: the last column visited in the final row).
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE.
- `abort`=1 in REQ or DONE: go to IDLE next cycle; no `done` pulse. `abort` has priority over `rd_ack`.
- `start` while `busy`=1 is ignored. Inputs latched at start are not re-sampled mid-scan.
- Address arithmetic is modulo 2^ADDR_W. Width and height are unsigned 13-bit.
- A 1×1 frame gives one request, then DONE.

## Timing
- Reset values: `rd_req`=0, `rd_addr`=0, `cur_col`=0, `cur_row`=0, `busy`=0, `done`=0, `cfg_err`=0; state=IDLE.
- `start` sampled at edge N gives `rd_req`=1 from cycle N+1.
- With `rd_ack` held high, a W×H frame produces W·H consecutive request cycles. `done` is high in the cycle after the final ack.
- All outputs are registered; `rd_ack` affects state only at the next edge.
- `n_rst` assertion mid-scan forces reset values immediately, with no `done`.

## Configuration
- `I_SCAN_SERPENTINE_EN` defined: odd rows (row[0]=1) traverse right-to-left.
  - At an even-row end: col stays width−1, row+1, addr+width.
  - Within an odd row: col−1, addr−1.
  - At an odd-row end (col==0): row+1, addr+width.
  - The last pixel is at col 0 if height is even, col width−1 if height is odd.
- Not defined: raster order only. No serpentine logic is present.

## Test plan
- Raster, base=0x1000, width=3, height=2, `rd_ack` tied high → addrs 0x1000,1001,1002,1003,1004,1005; (col,row) (0,0)…(2,1); `done` one cycle after the sixth ack.
- Ack backpressure: width=2, height=1, `rd_ack` low for 3 cycles on the first request → `rd_addr`=base and `rd_req`=1 held for 4 cycles; second request follows; `done` after it.
- `start` with width=0 or height=0 → `cfg_err` one cycle, `busy`=0, no `rd_req`.
- `abort` in cycle 2 of a 4×4 scan with `rd_ack`=1 → IDLE next cycle, no `done`. A new `start` restarts at (0,0)/base.
- Async `n_rst` low mid-scan → all outputs at reset values immediately. `start` mid-scan → ignored.
- With `I_SCAN_SERPENTINE_EN`, base=0, width=3, height=2 → addrs 0,1,2,5,4,3; cols 0,1,2,2,1,0; `done` after addr 3.

Source files
------------

// File: rtl/i_scan_controller.sv
// i_scan_controller: walks a programmed width x height frame one pixel at a
// time, issuing one rd_req/rd_ack read per pixel. Column, row and linear
// address (base + row*width + col) are tracked incrementally, no multiplier.
// Optional feature macro: I_SCAN_SERPENTINE_EN (odd rows run right-to-left).
module i_scan_controller #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [12:0]       img_width,
  input  logic [12:0]       img_height,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  output logic [12:0]       cur_col,
  output logic [12:0]       cur_row,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [12:0]       width_q, width_d;
  logic [12:0]       height_q, height_d;
  logic [12:0]       col_d, row_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] width_ext;
  logic              rd_req_d, busy_d, done_d, cfg_err_d;
  logic              row_end, last_pix;
`ifndef I_SCAN_SERPENTINE_EN
  logic [ADDR_W-1:0] row_base_q, row_base_d;
`endif

  assign width_ext = ADDR_W'(width_q);

  // Detect the final pixel of the current row and of the whole frame
  always_comb begin
    row_end  = 1'b0;
    last_pix = 1'b0;
`ifdef I_SCAN_SERPENTINE_EN
    if (cur_row[0]) row_end = (cur_col == 13'd0);
    else            row_end = (cur_col == width_q - 13'd1);
`else
    row_end = (cur_col == width_q - 13'd1);
`endif
    last_pix = row_end && (cur_row == height_q - 13'd1);
  end

  // Next-state, position advance and registered-output decode
  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    col_d     = cur_col;
    row_d     = cur_row;
    addr_d    = rd_addr;
`ifndef I_SCAN_SERPENTINE_EN
    row_base_d = row_base_q;
`endif
    rd_req_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((img_width == 13'd0) || (img_height == 13'd0)) begin
            cfg_err_d = 1'b1;
          end else begin
            width_d  = img_width;
            height_d = img_height;
            col_d    = '0;
            row_d    = '0;
            addr_d   = base_addr;
`ifndef I_SCAN_SERPENTINE_EN
            row_base_d = base_addr;
`endif
            state_d  = REQ;
            rd_req_d = 1'b1;
            busy_d   = 1'b1;
          end
        end
      end
      REQ: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          rd_req_d = 1'b1;
          busy_d   = 1'b1;
          if (rd_ack) begin
            if (last_pix) begin
              state_d  = DONE;
              rd_req_d = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end else begin
`ifdef I_SCAN_SERPENTINE_EN
              // Row change keeps the column, so the address just steps by width
              if (row_end) begin
                row_d  = cur_row + 13'd1;
                addr_d = rd_addr + width_ext;
              end else if (cur_row[0]) begin
                col_d  = cur_col - 13'd1;
                addr_d = rd_addr - ADDR_W'(1);
              end else begin
                col_d  = cur_col + 13'd1;
                addr_d = rd_addr + ADDR_W'(1);
              end
`else
              if (row_end) begin
                col_d      = '0;
                row_d      = cur_row + 13'd1;
                addr_d     = row_base_q + width_ext;
                row_base_d = row_base_q + width_ext;
              end else begin
                col_d  = cur_col + 13'd1;
                addr_d = rd_addr + ADDR_W'(1);
              end
`endif
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      cur_col  <= '0;
      cur_row  <= '0;
      rd_addr  <= '0;
`ifndef I_SCAN_SERPENTINE_EN
      row_base_q <= '0;
`endif
      rd_req   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      cur_col  <= col_d;
      cur_row  <= row_d;
      rd_addr  <= addr_d;
`ifndef I_SCAN_SERPENTINE_EN
      row_base_q <= row_base_d;
`endif
      rd_req   <= rd_req_d;
      busy     <= busy_d;
      done     <= done_d;
      cfg_err  <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_i_scan_controller.sv
// Scoreboard bench for i_scan_controller: the driver pushes the expected pixel
// sequence (computed as base + row*width + col) into a queue; the monitor
// compares every presented request against the queue head.
module tb_i_scan_controller;
  localparam int AW = 32;
  localparam int K_REQ = 0;
  localparam int K_ERR = 1;
  localparam int BUDGET = 4000;

  logic          clk = 1'b0;
  logic          n_rst, start, abort, rd_ack;
  logic [12:0]   img_width, img_height;
  logic [AW-1:0] base_addr;
  logic          rd_req, busy, done, cfg_err;
  logic [AW-1:0] rd_addr;
  logic [12:0]   cur_col, cur_row;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [12:0] col;
    logic [12:0] row;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done_due = 1'b0;

  always #5 clk = ~clk;

  i_scan_controller #(.ADDR_W(AW)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .img_width(img_width), .img_height(img_height), .base_addr(base_addr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name, string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endfunction

  // Reference ordering: row-major, odd rows reversed when serpentine is built
  function automatic void push_frame(int w, int h, logic [31:0] b);
    exp_t e;
    int c;
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        c = k;
`ifdef I_SCAN_SERPENTINE_EN
        if (r % 2 == 1) c = w - 1 - k;
`endif
        e.kind = K_REQ;
        e.addr = b + 32'(r * w + c);
        e.col  = 13'(c);
        e.row  = 13'(r);
        e.last = (r == h - 1) && (k == w - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  // Monitor: compare presented request / pulses against the queue head
  always @(negedge clk) begin
    exp_t e;
    bit due_next;
    due_next = 1'b0;
    if (!n_rst) begin
      done_due = 1'b0;
    end else begin
      check("done_pulse", 64'(done), 64'(done_due));
      if (rd_req) begin
        if (exp_q.size() == 0 || exp_q[0].kind != K_REQ) begin
          fail_now("unexpected_req", $sformatf("got rd_req addr 0x%0h, expected no request", rd_addr));
        end else begin
          e = exp_q[0];
          check("rd_addr", 64'(rd_addr), 64'(e.addr));
          check("cur_col", 64'(cur_col), 64'(e.col));
          check("cur_row", 64'(cur_row), 64'(e.row));
          check("busy_in_req", 64'(busy), 64'(1));
          if (rd_ack && !abort) begin
            void'(exp_q.pop_front());
            due_next = e.last;
          end
        end
      end
      if (cfg_err) begin
        if (exp_q.size() == 0 || exp_q[0].kind != K_ERR) begin
          fail_now("unexpected_cfg_err", "got cfg_err=1, expected 0");
        end else begin
          void'(exp_q.pop_front());
          check("cfg_err_busy", 64'(busy), 64'(0));
          check("cfg_err_rdreq", 64'(rd_req), 64'(0));
        end
      end
      done_due = due_next;
    end
  end

  task automatic check_reset_outputs(string tag);
    check({tag, "_rd_req"},  64'(rd_req),  64'(0));
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'(0));
    check({tag, "_cur_col"}, 64'(cur_col), 64'(0));
    check({tag, "_cur_row"}, 64'(cur_row), 64'(0));
    check({tag, "_busy"},    64'(busy),    64'(0));
    check({tag, "_done"},    64'(done),    64'(0));
    check({tag, "_cfg_err"}, 64'(cfg_err), 64'(0));
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: start, then drive acks (optionally stall/abort/reset/poke start)
  task automatic run_frame(input int w, input int h, input logic [31:0] b,
                           input int ack_pct, input int stall_first,
                           input int abort_at, input int rst_at, input bit poke_start);
    exp_t e;
    int cyc, reqc, stalls;
    bit ended_early;
    img_width  = 13'(w);
    img_height = 13'(h);
    base_addr  = b;
    start      = 1'b1;
    if (w == 0 || h == 0) begin
      e.kind = K_ERR; e.addr = '0; e.col = '0; e.row = '0; e.last = 1'b0;
      exp_q.push_back(e);
    end else begin
      push_frame(w, h, b);
    end
    @(posedge clk); #1;
    start      = 1'b0;
    img_width  = 13'($urandom);
    img_height = 13'($urandom);
    base_addr  = $urandom;
    if (w == 0 || h == 0) begin
      check("zero_dim_busy", 64'(busy), 64'(0));
      check("zero_dim_rdreq", 64'(rd_req), 64'(0));
      wait_cycles(2);
      check("cfg_err_consumed", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
      return;
    end
    check("start_rdreq", 64'(rd_req), 64'(1));
    check("start_busy", 64'(busy), 64'(1));
    cyc = 0; reqc = 0; stalls = 0; ended_early = 1'b0;
    while (busy && cyc < BUDGET) begin
      rd_ack = (stalls < stall_first) ? 1'b0 : ($urandom_range(99) < ack_pct);
      abort  = (cyc == abort_at);
      start  = poke_start && ($urandom_range(3) == 0);
      if (rd_req) reqc++;
      if (rd_req && !rd_ack) stalls++;
      if (cyc == rst_at) begin
        start = 1'b0; abort = 1'b0; rd_ack = 1'b0;
        #2 n_rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        exp_q.delete();
        @(posedge clk); #1;
        n_rst = 1'b1;
        ended_early = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (abort) begin
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_rdreq", 64'(rd_req), 64'(0));
        exp_q.delete();
        ended_early = 1'b1;
        break;
      end
    end
    start = 1'b0; rd_ack = 1'b0; abort = 1'b0;
    if (!ended_early) begin
      if (cyc >= BUDGET) begin
        fail_now("frame_timeout", $sformatf("busy still 1 after %0d cycles, expected frame end", cyc));
        exp_q.delete();
      end else begin
        check("req_cycles", 64'(reqc), 64'(w * h + stalls));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
      end
    end
    wait_cycles(2);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_rdreq", 64'(rd_req), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int w, h, ap, ab;
    logic [31:0] b;
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; rd_ack = 1'b0;
    img_width = '0; img_height = '0; base_addr = '0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    n_rst = 1'b1;
    wait_cycles(1);

    run_frame(3, 2, 32'h1000, 100, 0, -1, -1, 1'b0);
    run_frame(2, 1, 32'h0800, 100, 3, -1, -1, 1'b0);
    run_frame(0, 5, 32'h0100, 100, 0, -1, -1, 1'b0);
    run_frame(4, 0, 32'h0100, 100, 0, -1, -1, 1'b0);
    run_frame(4, 4, 32'h2000, 100, 0, 2, -1, 1'b0);
    run_frame(4, 4, 32'h2000, 100, 0, -1, -1, 1'b0);
    run_frame(5, 3, 32'h3000, 80, 0, -1, 4, 1'b0);
    run_frame(3, 3, 32'h4000, 70, 0, -1, -1, 1'b1);
    run_frame(3, 2, 32'h0, 100, 0, -1, -1, 1'b0);
    run_frame(1, 1, 32'h5555, 100, 0, -1, -1, 1'b0);
    run_frame(4, 3, 32'hFFFF_FFF8, 60, 0, -1, -1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      w  = $urandom_range(6, 1);
      h  = $urandom_range(5, 1);
      if ($urandom_range(9) == 0) w = 0;
      b  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
      ap = $urandom_range(100, 40);
      ab = ($urandom_range(4) == 0) ? $urandom_range(w * h + 2) : -1;
      run_frame(w, h, b, ap, 0, ab, -1, $urandom_range(1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
